// File: rtl/aprox_grad.sv
// aprox_grad: backward pass of the piecewise-linear activation approximator.
//
// Computes out_grad = g * f'(x), where f'(x) is the slope of the segment that
// x falls into (same segment boundaries as the forward block). All data is
// signed Q16.16. Three-stage valid/ready pipeline:
//   stage 1: upstream gradient g + 2-bit region code derived from x
//   stage 2: 64-bit signed product g * slope
//   stage 3: rounded (half up) and saturated 32-bit result
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   x/g pair valid
//   in_ready   pair accepted this cycle (combinational)
//   in_x       pre-activation, signed Q16.16
//   in_g       upstream gradient, signed Q16.16
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_grad   g*f'(x), signed Q16.16
//   out_sat    out_grad was clamped (qualified by out_valid)
//   xfer_cnt   number of completed output transfers, wraps
//
// Handshake: a pair moves in on in_valid & in_ready, a result moves out on
// out_valid & out_ready. The whole pipe advances together when the output
// register is empty or being drained (adv = !out_valid | out_ready); in_ready
// equals adv, so a stall at the output freezes every stage in place and
// nothing is dropped or duplicated. Empty slots (bubbles) travel as invalid
// stages and are overwritten freely.

module aprox_grad #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_g,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_grad,
  output logic             out_sat,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int PW = 2 * W;

  // Segment boundaries: 1.0 and 2.0 in Q16.16.
  localparam logic signed [W-1:0] X_LO = 32'sh0001_0000;
  localparam logic signed [W-1:0] X_HI = 32'sh0002_0000;

  // Segment slopes: -1.0 on the outer segments, ~-1/3 in the middle.
  localparam logic signed [W-1:0] SLOPE_OUTER = -32'sd65536;
  localparam logic signed [W-1:0] SLOPE_MID   = -32'sd21845;

  // Region codes carried through stage 1.
  localparam logic [1:0] REG_LOW  = 2'd0;
  localparam logic [1:0] REG_MID  = 2'd1;
  localparam logic [1:0] REG_HIGH = 2'd2;

  localparam logic signed [PW-1:0] ROUND_HALF = 64'sd32768;
  localparam logic signed [PW-1:0] RES_MAX    = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [PW-1:0] RES_MIN    = 64'shFFFF_FFFF_8000_0000;

  logic adv;

  // Stage 1
  logic                s1_valid;
  logic signed [W-1:0] s1_g;
  logic [1:0]          s1_region;

  // Stage 2
  logic                 s2_valid;
  logic signed [PW-1:0] s2_prod;

  // Combinational helpers
  logic [1:0]           region_c;
  logic signed [W-1:0]  slope_c;
  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] rnd_c;
  logic [W-1:0]         res_c;
  logic                 sat_c;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Region of x, signed compare; both boundaries belong to the middle segment.
  always_comb begin
    region_c = REG_MID;
    if ($signed(in_x) < X_LO) begin
      region_c = REG_LOW;
    end else if ($signed(in_x) > X_HI) begin
      region_c = REG_HIGH;
    end
  end

  always_comb begin
    slope_c = SLOPE_OUTER;
    if (s1_region == REG_MID) begin
      slope_c = SLOPE_MID;
    end
  end

  // Sign-extend both factors to the full product width before multiplying.
  assign prod_c = PW'(s1_g) * PW'(slope_c);

  // Round half up, then drop the fractional bits of the extra scale factor.
  assign rnd_c = (s2_prod + ROUND_HALF) >>> FRAC;

  always_comb begin
    res_c = rnd_c[W-1:0];
    sat_c = 1'b0;
    if (rnd_c > RES_MAX) begin
      res_c = RES_MAX[W-1:0];
      sat_c = 1'b1;
    end else if (rnd_c < RES_MIN) begin
      res_c = RES_MIN[W-1:0];
      sat_c = 1'b1;
    end
  end

  // Pipeline stages. Data registers load only when a valid sample moves in,
  // so a held output keeps its value and bubbles leave data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_g      <= '0;
      s1_region <= REG_LOW;
      s2_valid  <= 1'b0;
      s2_prod   <= '0;
      out_valid <= 1'b0;
      out_grad  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (in_valid) begin
        s1_g      <= $signed(in_g);
        s1_region <= region_c;
      end
      if (s1_valid) begin
        s2_prod <= prod_c;
      end
      if (s2_valid) begin
        out_grad <= res_c;
        out_sat  <= sat_c;
      end
    end
  end

  // Completed output transfers; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_aprox_grad.sv
// tb_aprox_grad: directed bench for aprox_grad.
// Drives inputs and samples outputs on the falling clock edge. Expected values
// are hand-computed Q16.16 constants; the burst test keeps them in an
// expected queue that is filled as samples are accepted.

module tb_aprox_grad;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_g;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_grad;
  logic        out_sat;
  logic [15:0] xfer_cnt;

  int passed;
  int total;
  int exp_cnt;

  logic [31:0] exp_q[$];

  // Burst vectors: g = k * 1.0, x alternating between the low segment (0)
  // and the middle segment (1.5). Expected = -k*1.0 or -k*21845 LSBs.
  logic [31:0] bx   [10];
  logic [31:0] bg   [10];
  logic [31:0] bexp [10];

  aprox_grad #(
    .W     (32),
    .FRAC  (16),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_g      (in_g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grad  (out_grad),
    .out_sat   (out_sat),
    .xfer_cnt  (xfer_cnt)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver / checker tasks
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check32({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check32({tag, " out_grad"},  out_grad,        32'd0);
    check32({tag, " out_sat"},   32'(out_sat),   32'd0);
    check32({tag, " xfer_cnt"},  32'(xfer_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    #1;
    check32({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // One sample through an idle pipe with out_ready held high; checks the
  // 3-cycle latency, the result, and the transfer count afterwards.
  task automatic single(input string tag, input logic [31:0] x, input logic [31:0] g,
                        input logic [31:0] exp_grad, input logic exp_sat);
    in_x      = x;
    in_g      = g;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check32({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_x     = '0;
    in_g     = '0;
    tick();
    check32({tag, " early valid"}, 32'(out_valid), 32'd0);
    tick();
    check32({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check32({tag, " out_grad"},  out_grad,        exp_grad);
    check32({tag, " out_sat"},   32'(out_sat),   32'(exp_sat));
    tick();
    exp_cnt++;
    check32({tag, " xfer_cnt"}, 32'(xfer_cnt), 32'(exp_cnt));
  endtask

  // Directed sequence
  initial begin
    int sent;
    int cyc;

    passed    = 0;
    total     = 0;
    exp_cnt   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_g      = '0;
    out_ready = 1'b0;

    bx[0] = 32'h0000_0000; bg[0] = 32'h0001_0000; bexp[0] = 32'hFFFF_0000;
    bx[1] = 32'h0001_8000; bg[1] = 32'h0002_0000; bexp[1] = 32'hFFFF_5556;
    bx[2] = 32'h0000_0000; bg[2] = 32'h0003_0000; bexp[2] = 32'hFFFD_0000;
    bx[3] = 32'h0001_8000; bg[3] = 32'h0004_0000; bexp[3] = 32'hFFFE_AAAC;
    bx[4] = 32'h0000_0000; bg[4] = 32'h0005_0000; bexp[4] = 32'hFFFB_0000;
    bx[5] = 32'h0001_8000; bg[5] = 32'h0006_0000; bexp[5] = 32'hFFFE_0002;
    bx[6] = 32'h0000_0000; bg[6] = 32'h0007_0000; bexp[6] = 32'hFFF9_0000;
    bx[7] = 32'h0001_8000; bg[7] = 32'h0008_0000; bexp[7] = 32'hFFFD_5558;
    bx[8] = 32'h0000_0000; bg[8] = 32'h0009_0000; bexp[8] = 32'hFFF7_0000;
    bx[9] = 32'h0001_8000; bg[9] = 32'h000A_0000; bexp[9] = 32'hFFFC_AAAE;

    @(negedge clk);
    do_reset("reset");

    // Basic slopes
    single("t1 x=0 g=2",     32'h0000_0000, 32'h0002_0000, 32'hFFFE_0000, 1'b0);
    single("t2 x=1.5 g=3",   32'h0001_8000, 32'h0003_0000, 32'hFFFF_0001, 1'b0);

    // Segment boundaries
    single("t3 x=65535",     32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_0000, 1'b0);
    single("t3 x=65536",     32'h0001_0000, 32'h0001_0000, 32'hFFFF_AAAB, 1'b0);
    single("t3 x=131072",    32'h0002_0000, 32'h0001_0000, 32'hFFFF_AAAB, 1'b0);
    single("t3 x=131073",    32'h0002_0001, 32'h0001_0000, 32'hFFFF_0000, 1'b0);
    single("t3 x=-2",        32'hFFFE_0000, 32'h0001_0000, 32'hFFFF_0000, 1'b0);

    // Saturation: -(-2^15) overflows the positive range
    single("t4 sat",         32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    // Largest negative result that still fits, no clamp
    single("t4 nosat",       32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0);

    // Burst of 10 with the output stalled on loop cycles 4..8
    do_reset("reset2");
    exp_q.delete();
    sent = 0;
    cyc  = 0;
    while ((sent < 10 || exp_q.size() > 0) && cyc < 100) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = (sent < 10);
      in_x      = (sent < 10) ? bx[sent] : 32'h0;
      in_g      = (sent < 10) ? bg[sent] : 32'h0;
      #1;
      if (out_valid && !out_ready) begin
        check32("burst stall in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check32("burst extra output", 32'(out_valid), 32'd0);
        end else begin
          check32("burst out_grad", out_grad, exp_q[0]);
          check32("burst out_sat", 32'(out_sat), 32'd0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            exp_cnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(bexp[sent]);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    in_x      = '0;
    in_g      = '0;
    out_ready = 1'b1;
    total++;
    assert (cyc < 100) passed++;
    else $error("FAIL burst timeout: observed %0d cycles expected < 100", cyc);
    check32("burst sent",     32'(sent),     32'd10);
    check32("burst xfer_cnt", 32'(xfer_cnt), 32'd10);
    check32("burst count model", 32'(exp_cnt), 32'(xfer_cnt));
    #1;
    check32("burst drained", 32'(out_valid), 32'd0);

    // Reset with three samples in flight and the output stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 32'h0000_0000;
    in_g      = 32'h0001_0000;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    check32("t6 pipe full", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check32("t6 out_valid", 32'(out_valid), 32'd0);
    check32("t6 xfer_cnt",  32'(xfer_cnt),  32'd0);
    check32("t6 out_grad",  out_grad,        32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
    single("t6 after reset", 32'h0000_0000, 32'h0004_0000, 32'hFFFC_0000, 1'b0);
    tick();
    check32("t6 no stale output", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
